// File: rtl/stage2_flatten_buffer.sv
`timescale 1ns/1ps
// stage2_flatten_buffer: collects NPT pooled points of CI channels, then
// streams them channel-major (ch0 p0..pN-1, ch1 ..) over valid/ready.
// Ports:
//   clk, reset_n           - clock, async active-low reset
//   i_in_valid, i_in_fmap  - pooled point strobe and CI*IBW-bit point
//   o_ot_valid, i_ot_ready - output handshake
//   o_ot_data, o_ot_last   - flattened word, last word of the map
//   o_busy, o_overflow     - draining, sticky dropped-strobe flag
module stage2_flatten_buffer #(
    parameter int CI  = 3,
    parameter int IBW = 19,
    parameter int NPT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_in_valid,
    input  logic [CI*IBW-1:0] i_in_fmap,
    output logic              o_ot_valid,
    input  logic              i_ot_ready,
    output logic [IBW-1:0]    o_ot_data,
    output logic              o_ot_last,
    output logic              o_busy,
    output logic              o_overflow
);

    localparam int NW = CI * NPT;
    localparam int PW = $clog2(NPT);
    localparam int RW = $clog2(NW);

    localparam logic [PW-1:0] PT_LAST = PW'(NPT - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(NW - 1);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [IBW-1:0] mem [NW];

    logic [0:0]    state;
    logic [PW-1:0] wr_cnt;
    logic [RW-1:0] rd_idx;
    logic [RW-1:0] rd_nxt;
    logic          wr_en;
    logic          xfer;

    assign wr_en  = (state == FILL) && i_in_valid;
    assign xfer   = o_ot_valid && i_ot_ready;
    assign rd_nxt = rd_idx + RW'(1);
    assign o_busy = (state == DRAIN);

    // Channel c lives at entries [c*NPT +: NPT], so a linear read index
    // walks the buffer channel-major.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < CI; c++) begin
                mem[RW'(c * NPT) + RW'(wr_cnt)] <= i_in_fmap[c*IBW +: IBW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FILL;
            wr_cnt     <= '0;
            rd_idx     <= '0;
            o_ot_valid <= 1'b0;
            o_ot_last  <= 1'b0;
            o_ot_data  <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (i_in_valid && (state == DRAIN)) begin
                o_overflow <= 1'b1;
            end
            case (state)
                FILL: begin
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + PW'(1);
                        // Entry 0 was written on an earlier edge, so the
                        // first word can be presented right away.
                        if (wr_cnt == PT_LAST) begin
                            state      <= DRAIN;
                            rd_idx     <= '0;
                            o_ot_valid <= 1'b1;
                            o_ot_last  <= 1'b0;
                            o_ot_data  <= mem[0];
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (rd_idx == RD_LAST) begin
                            state      <= FILL;
                            rd_idx     <= '0;
                            o_ot_valid <= 1'b0;
                            o_ot_last  <= 1'b0;
                        end else begin
                            rd_idx    <= rd_nxt;
                            o_ot_data <= mem[rd_nxt];
                            o_ot_last <= (rd_nxt == RD_LAST);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: doc/stage2_flatten_buffer.md
STAGE2_FLATTEN_BUFFER -- requirements
Module: stage2_flatten_buffer

Interface
REQ-001 The block SHALL have parameter CI, default 3, giving the number of pooled channels per input beat.
REQ-002 The block SHALL have parameter IBW, default 19, giving the bit width of one pooled value.
REQ-003 The block SHALL have parameter NPT, default 16, giving the pooled points per channel in one feature map; legal values are powers of two from 2 to 256.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_in_valid, input, 1 bit: single-cycle strobe marking a pooled point from the upstream pooling core.
REQ-007 The block SHALL have port i_in_fmap, input, CI*IBW bits: one point for all channels; channel c occupies bits [c*IBW +: IBW].
REQ-008 The block SHALL have port o_ot_valid, output, 1 bit: o_ot_data holds a valid flattened word.
REQ-009 The block SHALL have port i_ot_ready, input, 1 bit: the downstream FC stage accepts the word.
REQ-010 The block SHALL have port o_ot_data, output, IBW bits: flattened output word.
REQ-011 The block SHALL have port o_ot_last, output, 1 bit: marks the final word of a feature map.
REQ-012 The block SHALL have port o_busy, output, 1 bit: high while in DRAIN.
REQ-013 The block SHALL have port o_overflow, output, 1 bit: sticky flag for an input strobe that was dropped.

Function
REQ-014 The block SHALL implement two states: FILL, which is the reset state, and DRAIN.
REQ-015 In FILL, each cycle with i_in_valid=1 SHALL write channel c of i_in_fmap into buffer entry [c][wr_cnt] and increment wr_cnt.
REQ-016 When the NPT-th point is written, wr_cnt SHALL wrap to 0 and the state SHALL move to DRAIN on that same edge.
REQ-017 o_ot_valid SHALL rise in the cycle after that edge, so latency from the last input strobe to the first output word is 1 cycle.
REQ-018 In DRAIN, the output order SHALL be channel-major: ch0 p0..p(NPT-1), then ch1, up to ch(CI-1), for CI*NPT words in total.
REQ-019 A word SHALL be transferred only in a cycle where o_ot_valid=1 and i_ot_ready=1; the read index then advances by one.
REQ-020 While o_ot_valid=1 and i_ot_ready=0, o_ot_data and o_ot_last SHALL hold stable and o_ot_valid SHALL stay high.
REQ-021 o_ot_last SHALL equal 1 only while word index CI*NPT-1 is presented.
REQ-022 When the last word transfers, the state SHALL return to FILL, the read index SHALL clear to 0, and o_ot_valid SHALL be 0 in the next cycle.
REQ-023 i_ot_ready SHALL be ignored while o_ot_valid=0.
REQ-024 i_in_valid while in DRAIN, including the cycle of the final transfer, SHALL be dropped, SHALL leave buffer contents unchanged, and SHALL set o_overflow.
REQ-025 o_overflow SHALL remain set until reset.
REQ-026 Data SHALL pass bit-exact, with no arithmetic, sign change or truncation; o_ot_data is the stored IBW-bit value.
REQ-027 o_ot_data SHALL be registered; o_busy SHALL equal (state==DRAIN).
REQ-028 Counters SHALL be sized $clog2(NPT) for the point index and $clog2(CI*NPT) for the read index.
REQ-029 Buffer storage SHALL hold CI*NPT*IBW bits and SHALL NOT require reset.

Reset
REQ-030 On reset_n=0, the block SHALL asynchronously clear: state to FILL, wr_cnt and read index to 0, and o_ot_valid, o_ot_last, o_busy, o_overflow and o_ot_data to 0.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the partial map, and no stale word SHALL be output after release.
REQ-032 The first i_in_valid after reset release SHALL be written to point 0.

Verification
REQ-033 Basic fill/drain: CI=3, NPT=16, 16 strobes with ch c of point p = c*100+p, i_ot_ready=1 -> o_ot_valid rises 1 cycle after the 16th strobe; 48 consecutive words 0,1..15,100..115,200..215; o_ot_last only on 215.
REQ-034 Backpressure: i_ot_ready=0 for 5 cycles on word 17 (value 101) -> data stays 101 and valid stays high; afterwards the sequence resumes with no loss or duplication.
REQ-035 Overflow: strobe i_in_valid during DRAIN and in the final-transfer cycle -> o_overflow=1 and stays 1; the next map starts at point 0 with the correct data.
REQ-036 Reset mid-operation: pulse reset_n low after 7 fill strobes and again at drain word 20 -> all outputs 0 immediately; a following full 16-point map drains correctly.
REQ-037 Back-to-back maps: two maps with strobes every 2 cycles and random i_ot_ready -> both maps are output in order, with exactly two o_ot_last pulses.
REQ-038 Extremes: values 0x7FFFF and 0x00000 on alternating channels -> the bit-exact pattern is observed at the output.
